// File: rtl/hack_alu_pkg.sv
// -----------------------------------------------------------------------------
// hack_alu_pkg
// Shared definitions for the Hack-style ALU:
//   - HACK_WIDTH     : default datapath width (two's complement)
//   - OP_*           : bit positions of the six control bits inside op[5:0]
//   - ENC_*          : the 18 canonical op encodings (op[5:0] = no,f,ny,zy,nx,zx)
//   - hack_flags_t   : packed {ng, zr} flag pair
//   - hack_zr()      : zero-flag helper used by the core
// Every one of the 64 encodings is legal; the ENC_* list only names the
// commonly used ones.
// -----------------------------------------------------------------------------
package hack_alu_pkg;

  localparam int HACK_WIDTH = 16;

  // Bit positions within op.
  localparam int OP_ZX = 0;
  localparam int OP_NX = 1;
  localparam int OP_ZY = 2;
  localparam int OP_NY = 3;
  localparam int OP_F  = 4;
  localparam int OP_NO = 5;

  // Canonical encodings, written op[5:0] MSB first.
  localparam logic [5:0] ENC_ZERO    = 6'b010101;
  localparam logic [5:0] ENC_ONE     = 6'b111111;
  localparam logic [5:0] ENC_NEG_ONE = 6'b010111;
  localparam logic [5:0] ENC_X       = 6'b001100;
  localparam logic [5:0] ENC_Y       = 6'b000011;
  localparam logic [5:0] ENC_NOT_X   = 6'b101100;
  localparam logic [5:0] ENC_NOT_Y   = 6'b100011;
  localparam logic [5:0] ENC_NEG_X   = 6'b111100;
  localparam logic [5:0] ENC_NEG_Y   = 6'b110011;
  localparam logic [5:0] ENC_X_INC   = 6'b111110;
  localparam logic [5:0] ENC_Y_INC   = 6'b111011;
  localparam logic [5:0] ENC_X_DEC   = 6'b011100;
  localparam logic [5:0] ENC_Y_DEC   = 6'b010011;
  localparam logic [5:0] ENC_X_ADD_Y = 6'b010000;
  localparam logic [5:0] ENC_X_SUB_Y = 6'b110010;
  localparam logic [5:0] ENC_Y_SUB_X = 6'b111000;
  localparam logic [5:0] ENC_X_AND_Y = 6'b000000;
  localparam logic [5:0] ENC_X_OR_Y  = 6'b101010;

  // Flag pair as carried between core and register stage.
  typedef struct packed {
    logic ng;
    logic zr;
  } hack_flags_t;

  // Zero test on an arbitrary-width value passed zero-extended to 64 bits.
  function automatic logic hack_zr(input logic [63:0] v);
    return (v == 64'd0);
  endfunction

endpackage

// File: rtl/hack_alu_core.sv
// -----------------------------------------------------------------------------
// hack_alu_core
// Purely combinational Hack ALU datapath.
// Ports:
//   x   [WIDTH-1:0] in  : operand X
//   y   [WIDTH-1:0] in  : operand Y
//   op  [5:0]       in  : {no, f, ny, zy, nx, zx}
//   out [WIDTH-1:0] out : f(x,y)
//   zr              out : out == 0
//   ng              out : out[WIDTH-1]
// The steps are evaluated strictly in order: zero, then negate each operand,
// then add or AND, then optionally invert the result. Flags are taken from
// the final (post-inversion) value.
// -----------------------------------------------------------------------------
module hack_alu_core
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic             zx, nx, zy, ny, fsel, no;
  logic [WIDTH-1:0] x1, x2, y1, y2;
  logic [WIDTH-1:0] sum, conj, o;

  assign zx   = op[OP_ZX];
  assign nx   = op[OP_NX];
  assign zy   = op[OP_ZY];
  assign ny   = op[OP_NY];
  assign fsel = op[OP_F];
  assign no   = op[OP_NO];

  // Operand conditioning.
  assign x1 = zx ? '0 : x;
  assign x2 = nx ? ~x1 : x1;
  assign y1 = zy ? '0 : y;
  assign y2 = ny ? ~y1 : y1;

  // WIDTH-bit sum: carry-out is intentionally dropped (no overflow flag).
  assign sum  = x2 + y2;
  assign conj = x2 & y2;
  assign o    = fsel ? sum : conj;

  assign out = no ? ~o : o;

  // Flags come from the final result, after the optional inversion.
  assign zr = hack_zr(64'(out));
  assign ng = out[WIDTH-1];

endmodule

// File: rtl/hack_alu.sv
// -----------------------------------------------------------------------------
// hack_alu
// Hack-style 16-bit ALU with a single registered output stage.
// Ports:
//   clk              in  : system clock, rising edge
//   rst              in  : asynchronous active-high reset
//   in_valid         in  : qualifies x, y, op this cycle
//   x, y [WIDTH-1:0] in  : operands
//   op   [5:0]       in  : {no, f, ny, zy, nx, zx}
//   result[WIDTH-1:0] out: registered f(x,y), signed
//   zr               out : registered, result == 0
//   ng               out : registered, result MSB
//   out_valid        out : registered in_valid
//
// Handshake: valid-only, no back-pressure. A beat is transferred on every
// rising clk edge where in_valid=1; its result appears one cycle later with
// out_valid=1 for exactly that cycle. On edges with in_valid=0, result/zr/ng
// keep their last captured values and out_valid drops to 0. Reset clears the
// stage immediately and discards any beat that has not yet been captured.
// -----------------------------------------------------------------------------
module hack_alu
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng,
  output logic             out_valid
);

  logic [WIDTH-1:0] core_out;
  hack_flags_t      core_flags;
  hack_flags_t      flags_q;

  hack_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x   (x),
    .y   (y),
    .op  (op),
    .out (core_out),
    .zr  (core_flags.zr),
    .ng  (core_flags.ng)
  );

  // Data and flags load only on valid beats; they hold otherwise.
  // Reset value 0 implies zr=1, ng=0 so the flags stay consistent with result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result     <= '0;
      flags_q.zr <= 1'b1;
      flags_q.ng <= 1'b0;
    end else if (in_valid) begin
      result  <= core_out;
      flags_q <= core_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  assign zr = flags_q.zr;
  assign ng = flags_q.ng;

endmodule

// File: tb/tb_hack_alu.sv
// -----------------------------------------------------------------------------
// tb_hack_alu
// Self-checking bench for hack_alu: driver tasks push the expected
// {ng, zr, result} of every valid beat into exp_q; a monitor on the falling
// edge pops and compares whenever out_valid is high, and otherwise checks
// that the outputs hold their last value (or reset values while rst=1).
// -----------------------------------------------------------------------------
module tb_hack_alu;
  import hack_alu_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] x, y;
  logic [5:0]   op;
  logic [W-1:0] result;
  logic         zr, ng, out_valid;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_exp;
  int           tests;
  int           fails;
  bit           done;

  hack_alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .op        (op),
    .result    (result),
    .zr        (zr),
    .ng        (ng),
    .out_valid (out_valid)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Plain integer arithmetic: bitwise NOT of a 16-bit value is 65535 - v.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [5:0] o);
    int unsigned xv, yv, r;
    xv = o[0] ? 0 : int'(a);
    if (o[1]) xv = 65535 - xv;
    yv = o[2] ? 0 : int'(b);
    if (o[3]) yv = 65535 - yv;
    r = o[4] ? (xv + yv) % 65536 : (xv & yv);
    if (o[5]) r = 65535 - r;
    return r[W-1:0];
  endfunction

  // Pack {ng, zr, result} from a result value.
  function automatic logic [W+1:0] pack_exp(input logic [W-1:0] r);
    return {r[W-1], (r == '0), r};
  endfunction

  localparam logic [W+1:0] RESET_EXP = {1'b0, 1'b1, 16'h0000};

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got ng/zr/result=%b/%b/%h, required %b/%b/%h",
               name, act[W+1], act[W], act[W-1:0], exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Applies one beat at posedge+1; valid beats record their expected output.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [5:0] o, input logic [W-1:0] expv);
    @(posedge clk);
    #1;
    in_valid = v;
    x        = a;
    y        = b;
    op       = o;
    if (v) exp_q.push_back(pack_exp(expv));
  endtask

  // Called at posedge+1: asserts rst mid-cycle, checks outputs react before
  // any clock edge, drops pending expectations, releases after the next edge.
  task automatic reset_pulse(input string name);
    #2;
    rst = 1'b1;
    #1;
    check({name, "_async"}, {ng, zr, result}, RESET_EXP);
    check_bit({name, "_async_valid"}, out_valid, 1'b0);
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    last_exp = RESET_EXP;
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        check("reset_hold", {ng, zr, result}, RESET_EXP);
        check_bit("reset_out_valid", out_valid, 1'b0);
        last_exp = RESET_EXP;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_valid: got out_valid=1 result=%h, required no output", result);
        end else begin
          last_exp = exp_q.pop_front();
          check("result", {ng, zr, result}, last_exp);
        end
      end else begin
        check("hold", {ng, zr, result}, last_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0]   sweep_op [18];
  logic [W-1:0] sweep_exp[18];
  logic [W-1:0] corner   [4];

  initial begin
    sweep_op  = '{ENC_ZERO, ENC_ONE, ENC_NEG_ONE, ENC_X, ENC_Y, ENC_NOT_X, ENC_NOT_Y,
                  ENC_NEG_X, ENC_NEG_Y, ENC_X_INC, ENC_Y_INC, ENC_X_DEC, ENC_Y_DEC,
                  ENC_X_ADD_Y, ENC_X_SUB_Y, ENC_Y_SUB_X, ENC_X_AND_Y, ENC_X_OR_Y};
    // Results for x=2, y=3 in the same order.
    sweep_exp = '{16'd0, 16'd1, 16'hFFFF, 16'd2, 16'd3, 16'hFFFD, 16'hFFFC,
                  16'hFFFE, 16'hFFFD, 16'd3, 16'd4, 16'd1, 16'd2, 16'd5,
                  16'hFFFF, 16'd1, 16'd2, 16'd3};
    corner    = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

    tests    = 0;
    fails    = 0;
    done     = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    op       = '0;

    #1;
    check("power_on_reset", {ng, zr, result}, RESET_EXP);
    check_bit("power_on_out_valid", out_valid, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after release: monitor checks outputs stay at reset values.
    repeat (3) drive(1'b0, 16'h1234, 16'h5678, ENC_X_ADD_Y, 16'h0);

    // Reset asserted between edges while idle.
    drive(1'b0, 16'h0, 16'h0, ENC_ZERO, 16'h0);
    reset_pulse("idle_reset");
    repeat (2) drive(1'b0, 16'hAAAA, 16'h5555, ENC_X_OR_Y, 16'h0);

    // Canonical sweep, x=2, y=3.
    for (int i = 0; i < 18; i++) drive(1'b1, 16'd2, 16'd3, sweep_op[i], sweep_exp[i]);

    // Wrap-around.
    drive(1'b1, 16'h7FFF, 16'd0, ENC_X_INC, 16'h8000);
    drive(1'b1, 16'hFFFF, 16'd0, ENC_X_INC, 16'h0000);

    // Hold: 5 is captured, then inputs change with in_valid low.
    drive(1'b1, 16'd2, 16'd3, ENC_X_ADD_Y, 16'd5);
    drive(1'b0, 16'h1111, 16'h2222, ENC_NEG_ONE, 16'h0);
    drive(1'b0, 16'h7FFF, 16'h0001, ENC_ONE, 16'h0);

    // Reset mid-stream with a valid x+y pending, then x-y gives -1.
    drive(1'b1, 16'd2, 16'd3, ENC_X_ADD_Y, 16'd5);
    reset_pulse("midstream_reset");
    drive(1'b1, 16'd2, 16'd3, ENC_X_SUB_Y, 16'hFFFF);
    drive(1'b0, 16'd0, 16'd0, ENC_ZERO, 16'h0);

    // Randomized: all 64 op codes, mixed with corner operands and idle beats.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b;
      logic [5:0]   o;
      logic         v;
      a = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      o = (i < 64) ? 6'(i) : 6'($urandom_range(0, 63));
      v = ($urandom_range(0, 9) != 0);
      drive(v, a, b, o, ref_alu(a, b, o));
    end

    // Drain: every expected beat must have been observed within a bounded wait.
    for (int i = 0; i < 5; i++) drive(1'b0, 16'h0, 16'h0, ENC_ZERO, 16'h0);
    check("drain_queue_empty", (W+2)'(exp_q.size()), (W+2)'(0));

    done = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
